// File: rtl/heart_pkg.sv
// Shared cardiac-model definitions: state encoding and default intervals, so the
// pacemaker bench and the heart model agree on timing.
package heart_pkg;

  typedef enum logic [1:0] {
    ST_ATRIUM    = 2'b00,
    ST_VENTRICLE = 2'b01,
    ST_REFRACT   = 2'b10
  } state_e;

  localparam int DEF_A_PERIOD = 20;
  localparam int DEF_AV_DELAY = 30;
  localparam int DEF_REFRACT  = 4;
  localparam int DEF_CW       = 8;
  localparam int DEF_BEAT_W   = 16;

endpackage

// File: rtl/heart_timer.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module heart_timer #(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  assign zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt_q <= RST_VAL;
    else if (load)         cnt_q <= load_val;
    else if (en && !zero)  cnt_q <= cnt_q - CW'(1);
  end

endmodule

// File: rtl/heart_model.sv
// Cardiac model: turns pace pulses into paced beats and generates intrinsic
// atrial/ventricular sense pulses, with a saturating ventricular beat counter.
module heart_model
  import heart_pkg::*;
#(
  parameter int A_PERIOD = DEF_A_PERIOD,
  parameter int AV_DELAY = DEF_AV_DELAY,
  parameter int REFRACT  = DEF_REFRACT,
  parameter int CW       = DEF_CW,
  parameter int BEAT_W   = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pa,
  input  logic              pv,
  input  logic              a_en,
  input  logic              av_en,
  output logic              sa,
  output logic              sv,
  output logic              a_paced,
  output logic              v_paced,
  output logic [BEAT_W-1:0] beat_cnt
);

  localparam logic [CW-1:0] LD_A  = CW'(A_PERIOD - 1);
  localparam logic [CW-1:0] LD_AV = CW'(AV_DELAY - 1);
  localparam logic [CW-1:0] LD_RF = CW'(REFRACT - 1);

  state_e            state_q, state_d;
  logic              sa_q, sv_q, ap_q, vp_q;
  logic              sa_d, sv_d, ap_d, vp_d;
  logic [BEAT_W-1:0] beat_q;
  logic              t_load, t_zero;
  logic [CW-1:0]     t_val;

  heart_timer #(.CW(CW), .RST_VAL(LD_A)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (1'b1),
    .zero     (t_zero)
  );

  // Pace is tested before the intrinsic condition so it wins on coincidence.
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = LD_A;
    sa_d    = 1'b0;
    sv_d    = 1'b0;
    ap_d    = 1'b0;
    vp_d    = 1'b0;
    case (state_q)
      ST_ATRIUM: begin
        if (pa)                 ap_d = 1'b1;
        else if (a_en && t_zero) sa_d = 1'b1;
        if (ap_d || sa_d) begin
          state_d = ST_VENTRICLE;
          t_load  = 1'b1;
          t_val   = LD_AV;
        end
      end
      ST_VENTRICLE: begin
        if (pv)                  vp_d = 1'b1;
        else if (av_en && t_zero) sv_d = 1'b1;
        if (vp_d || sv_d) begin
          state_d = ST_REFRACT;
          t_load  = 1'b1;
          t_val   = LD_RF;
        end
      end
      ST_REFRACT: begin
        if (t_zero) begin
          state_d = ST_ATRIUM;
          t_load  = 1'b1;
          t_val   = LD_A;
        end
      end
      default: begin
        state_d = ST_ATRIUM;
        t_load  = 1'b1;
        t_val   = LD_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ATRIUM;
      sa_q    <= 1'b0;
      sv_q    <= 1'b0;
      ap_q    <= 1'b0;
      vp_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sv_q    <= sv_d;
      ap_q    <= ap_d;
      vp_q    <= vp_d;
      if ((sv_d || vp_d) && (beat_q != '1))
        beat_q <= beat_q + BEAT_W'(1);
    end
  end

  assign sa       = sa_q;
  assign sv       = sv_q;
  assign a_paced  = ap_q;
  assign v_paced  = vp_q;
  assign beat_cnt = beat_q;

endmodule

// File: tb/tb_heart_model.sv
// Directed bench for heart_model: edge-numbered vector table plus hand-written
// sequences for async reset and beat-counter saturation.
module tb_heart_model;
  import heart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pa = 1'b0, pv = 1'b0, a_en = 1'b1, av_en = 1'b1;
  logic        sa, sv, a_paced, v_paced;
  logic [15:0] beat_cnt;
  logic        sa3, sv3, ap3, vp3;
  logic [2:0]  beat3;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int spur;

  always #5 clk = ~clk;

  heart_model dut (
    .clk(clk), .rst(rst), .pa(pa), .pv(pv), .a_en(a_en), .av_en(av_en),
    .sa(sa), .sv(sv), .a_paced(a_paced), .v_paced(v_paced), .beat_cnt(beat_cnt)
  );

  heart_model #(.BEAT_W(3)) dut3 (
    .clk(clk), .rst(rst), .pa(pa), .pv(pv), .a_en(a_en), .av_en(av_en),
    .sa(sa3), .sv(sv3), .a_paced(ap3), .v_paced(vp3), .beat_cnt(beat3)
  );

  typedef struct {
    bit         rst;
    int         at;
    bit         pa, pv, a_en, av_en;
    logic [3:0] ev;   // {sa, sv, a_paced, v_paced}
    int         beat;
  } vec_t;

  vec_t tbl[20];

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pa  = 1'b0;
    pv  = 1'b0;
    step();
    step();
    chk("reset events", {sa, sv, a_paced, v_paced}, 0);
    chk("reset beat", beat_cnt, 0);
    rst = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    //         rst  at  pa pv a  av  ev       beat
    tbl[0]  = '{1,  20, 0, 0, 1, 1, 4'b1000, 0};
    tbl[1]  = '{0,  50, 0, 0, 1, 1, 4'b0100, 1};
    tbl[2]  = '{0,  74, 0, 0, 1, 1, 4'b1000, 1};
    tbl[3]  = '{0,  80, 1, 0, 1, 1, 4'b0000, 1};   // pa in VENTRICLE ignored
    tbl[4]  = '{0, 104, 0, 0, 1, 1, 4'b0100, 2};
    tbl[5]  = '{0, 106, 0, 1, 1, 1, 4'b0000, 2};   // pv in REFRACT ignored
    tbl[6]  = '{0, 107, 1, 0, 1, 1, 4'b0000, 2};   // pa in REFRACT ignored
    tbl[7]  = '{0, 128, 0, 0, 1, 1, 4'b1000, 2};
    tbl[8]  = '{0, 158, 0, 0, 1, 1, 4'b0100, 3};
    tbl[9]  = '{0, 182, 1, 0, 1, 1, 4'b0010, 3};   // pa coincides with intrinsic sa
    tbl[10] = '{0, 212, 0, 1, 1, 1, 4'b0001, 4};   // pv coincides with intrinsic sv
    tbl[11] = '{0, 236, 0, 0, 1, 0, 4'b1000, 4};
    tbl[12] = '{0, 271, 0, 1, 1, 0, 4'b0001, 5};   // block: only pv conducts
    tbl[13] = '{0, 295, 0, 0, 1, 1, 4'b1000, 5};
    tbl[14] = '{0, 325, 0, 0, 1, 1, 4'b0100, 6};
    tbl[15] = '{1,  10, 1, 0, 0, 1, 4'b0010, 0};   // bradycardia: a_en=0
    tbl[16] = '{0,  40, 0, 0, 0, 1, 4'b0100, 1};
    tbl[17] = '{0, 250, 0, 0, 0, 1, 4'b0000, 1};
    tbl[18] = '{0, 260, 1, 0, 0, 1, 4'b0010, 1};
    tbl[19] = '{0, 290, 0, 0, 0, 1, 4'b0100, 2};

    for (int i = 0; i < 20; i++) begin
      a_en  = tbl[i].a_en;
      av_en = tbl[i].av_en;
      if (tbl[i].rst) do_reset();
      spur = 0;
      while (ecnt < tbl[i].at - 1) begin
        step();
        if ({sa, sv, a_paced, v_paced} != 4'b0000) spur++;
      end
      pa = tbl[i].pa;
      pv = tbl[i].pv;
      step();
      pa = 1'b0;
      pv = 1'b0;
      chk($sformatf("v%0d events", i), {sa, sv, a_paced, v_paced}, tbl[i].ev);
      chk($sformatf("v%0d beat", i), beat_cnt, tbl[i].beat);
      chk($sformatf("v%0d quiet", i), spur, 0);
    end

    // Async reset while sa is high (just entered VENTRICLE), between edges.
    a_en  = 1'b1;
    av_en = 1'b1;
    do_reset();
    while (ecnt < 74) step();
    chk("pre-rst sa", sa, 1);
    chk("pre-rst beat", beat_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst events", {sa, sv, a_paced, v_paced}, 0);
    chk("async rst beat", beat_cnt, 0);
    #1 rst = 1'b1;
    ecnt = 0;
    while (ecnt < 19) step();
    chk("post-rst no sa@19", sa, 0);
    step();
    chk("post-rst sa@20", sa, 1);

    // Saturation: 7 beats fill the 3-bit counter, the 9th must not wrap.
    while (ecnt < 374) step();
    chk("beat16 after 7", beat_cnt, 7);
    chk("beat3 after 7", beat3, 7);
    while (ecnt < 482) step();
    chk("beat16 after 9", beat_cnt, 9);
    chk("beat3 saturated", beat3, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heart_model.md
# heart_model

Synthesizable cardiac model forming the other end of the pacemaker's sense/pace interface. It consumes atrial/ventricular pace pulses (`pa`, `pv`) and produces atrial/ventricular sense pulses (`sa`, `sv`), so a pacemaker can run closed-loop on the board or in simulation. Intrinsic atrial rhythm and AV conduction can each be disabled independently to model bradycardia and heart block. A saturating beat counter gives a visible result.

## Interface
- `A_PERIOD`, 20: intrinsic atrial interval in cycles, counted from entry to ATRIUM (1..2^CW-1).
- `AV_DELAY`, 30: intrinsic AV conduction delay in cycles (1..2^CW-1).
- `REFRACT`, 4: ventricular refractory period in cycles (1..2^CW-1).
- `CW`, 8: interval counter width.
- `BEAT_W`, 16: beat counter width.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `pa` in 1: atrial pace pulse from the pacemaker.
- `pv` in 1: ventricular pace pulse from the pacemaker.
- `a_en` in 1: intrinsic atrial activity enabled.
- `av_en` in 1: intrinsic AV conduction enabled.
- `sa` out 1: one-cycle pulse for an intrinsic atrial beat.
- `sv` out 1: one-cycle pulse for an intrinsic ventricular beat.
- `a_paced` out 1: one-cycle pulse for an atrial beat caused by `pa`.
- `v_paced` out 1: one-cycle pulse for a ventricular beat caused by `pv`.
- `beat_cnt` out BEAT_W: count of ventricular beats (intrinsic plus paced). Saturates at all-ones.

## Operation
- **Reset:** while `rst`=0, the block is held in ATRIUM with `cnt`=A_PERIOD-1. `sa`, `sv`, `a_paced`, `v_paced` and `beat_cnt` are 0. Reset asserted mid-operation takes effect immediately, with no clock edge required.
- **ATRIUM**
  - If `pa`=1: paced atrial beat. `a_paced` pulses. Go to VENTRICLE with `cnt`=AV_DELAY-1.
  - Else if `a_en`=1 and `cnt`=0: intrinsic atrial beat. `sa` pulses. Go to VENTRICLE with `cnt`=AV_DELAY-1.
  - Else if `cnt`≠0: decrement `cnt`.
  - Else: hold at 0. This occurs with `a_en`=0; the block waits indefinitely for `pa`.
  - If `pa` and the intrinsic condition occur in the same cycle, pace wins: only `a_paced` pulses, never `sa`.
- **VENTRICLE**
  - `pa` is ignored.
  - If `pv`=1: paced ventricular beat. `v_paced` pulses.
  - Else if `av_en`=1 and `cnt`=0: intrinsic ventricular beat. `sv` pulses.
  - Else: decrement `cnt`, or hold at 0.
  - On either beat: `beat_cnt` increments (saturating), then go to REFRACT with `cnt`=REFRACT-1. Pace wins on coincidence.
- **REFRACT**
  - `pa` and `pv` are ignored.
  - At `cnt`=0, go to ATRIUM with `cnt`=A_PERIOD-1. Otherwise decrement.
- All four event outputs are registered. At most one of them is high in any cycle.

## Timing
- An event is decided on the edge where its condition holds. The corresponding output is high for exactly the following cycle.
- With no pacing and both enables set:
  - `sa` rises on edge A_PERIOD after reset release.
  - `sv` rises AV_DELAY edges after `sa`.
  - The next `sa` rises REFRACT+A_PERIOD edges after `sv`.
  - Intrinsic period = A_PERIOD+AV_DELAY+REFRACT cycles (54 with defaults).
- Pace responses:
  - `pa` sampled high in ATRIUM: `a_paced` is high the next cycle. The ventricular interval starts the same edge.
  - `pv` sampled high in VENTRICLE: `v_paced` is high the next cycle.
- `beat_cnt` updates on the same edge that sets `sv`/`v_paced`.
- Inputs are level-sampled every edge; a multi-cycle `pa` acts once, since subsequent cycles are in VENTRICLE.

## Structure
- Shared package `heart_pkg` holds:
  - the state encoding: ATRIUM=2'b00, VENTRICLE=2'b01, REFRACT=2'b10, with 2'b11 recovering to ATRIUM;
  - the default interval constants, so the pacemaker bench and this block agree.
- One sub-module, `heart_timer`: a CW-bit loadable down-counter with `load`, `load_val`, `en` and a `zero` flag.
- The top level holds the FSM, the output registers and `beat_cnt`.

## Test plan
1. Defaults, `a_en`=`av_en`=1, no pacing → `sa` on edge 20, `sv` on edge 50, `beat_cnt`=1, next `sa` on edge 74.
2. `a_en`=0 → no `sa` for 200 cycles. `pa` at edge 10 → `a_paced` at edge 11, `sv` at edge 41, `sa` never asserted.
3. `av_en`=0 after an intrinsic `sa`, `pv` 35 cycles later → `v_paced` one cycle, no `sv`, `beat_cnt` increments, REFRACT entered.
4. `pa` on the same edge that `cnt` reaches 0 in ATRIUM → only `a_paced`. `pv` coincident with intrinsic `sv` → only `v_paced`.
5. `pa` during VENTRICLE and `pa`/`pv` during REFRACT → no state change, no outputs, interval timing unchanged.
6. Async `rst`=0 mid-VENTRICLE → all outputs 0 immediately. After release, `sa` on edge 20. With `BEAT_W`=3, eight beats → `beat_cnt` holds at 7.
